cpu_fetch_buf: RTL and testbench
================================

// Module: cpu_fetch_buf
// PURPOSE
//  N-wide instruction fetch with a decoupling instruction queue, between Icache and decoder.
//  Issues FETCH_W sequential PCs per cycle and enqueues the contiguous hit prefix, byte-reversed.
//  Presents up to FETCH_W queued instructions per cycle; the decoder consumes a count from the head.
//  Redirects from two ALU ports flush the queue and restart fetch.
// PARAMETERS
//  FETCH_W   2      lanes per cycle, Icache and decoder side (1..4)
//  Q_DEPTH   8      queue entries; power of 2, >= FETCH_W
//  RESET_PC  32'h0  PC loaded at reset
// PORTS
//  clk           in   1          clock
//  rst_n         in   1          asynchronous reset, active low
//  rdy           in   1          global enable; 0 = hold all state
//  ic_pc_out     out  32*W       lane i address = pc + 4*i
//  ic_en_out     out  W          lane read enable; 0 when queue free < i+1
//  ic_hit        in   W          lane i hit
//  ic_inst       in   32*W       lane i raw (little-endian) instruction
//  en_jmp0       in   1          redirect request, port 0 (older, higher priority)
//  jmp_addr0     in   32         target 0
//  en_jmp1       in   1          redirect request, port 1
//  jmp_addr1     in   32         target 1
//  dec_valid_out out  W          lane j holds queue head+j
//  dec_pc_out    out  32*W       PC of lane j
//  dec_inst_out  out  32*W       byte-reversed instruction; OP_NOP when invalid
//  dec_take      in   clog2(W+1) entries consumed this cycle; <= popcount(dec_valid_out)
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC, queue empty, dec_valid_out=0, dec_inst_out=OP_NOP,
//    dec_pc_out=0. Reset mid-operation discards all queued entries.
//  - rdy=0: no state change. Pending dec_take and redirects are ignored; their sources are also stalled.
//  - Accept count a = number of leading lanes with ic_hit=1 (lane i requires lanes 0..i-1 hit),
//    capped at free = Q_DEPTH - count. Push lanes 0..a-1 as {pc+4i, REV(inst)}. pc += 4*a.
//  - Miss on lane 0, or free=0: a=0, pc holds. Icache is re-queried every cycle.
//  - Latency: an instruction accepted at edge k appears on dec_*_out after edge k, i.e. one cycle
//    from Icache hit to decoder.
//  - Outputs are driven from queue state after the edge. dec_valid_out[j] = (count > j).
//  - Pop dec_take entries from the head. Push and pop happen at the same edge. count' = count + a - take.
//    Full and empty are exact, with no lost slot. Pointers wrap modulo Q_DEPTH.
//  - Redirect: r = en_jmp0 | en_jmp1. target = en_jmp0 ? jmp_addr0 : jmp_addr1, with bits[1:0] forced to 0.
//    At the edge: pc <= target, queue flushed, that cycle's hits and dec_take discarded.
//    Next cycle: dec_valid_out=0. Cycle after that: first target instructions, if they hit.
//  - Both redirects asserted: port 0 wins. Port 1 is dropped silently.
//  - dec_take > valid count is illegal. Assertion in sim; RTL clamps it to the valid count.
//  - PC arithmetic is 32-bit and wraps at 2^32 with no flag.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_redir_cnt[31:0].
//    perf_stall_cnt counts rdy=1 cycles with a=0 and no redirect.
//    perf_redir_cnt counts accepted redirects.
//    Both reset to 0 and wrap.
//  FETCH_PERF_EN undefined: ports and logic absent. Otherwise behaviour is identical.
// STRUCTURE
//  Shared package/defines (cpu_defs): addr_t, word_t, OP_NOP, REV byte-swap macro, and the
//  fetch entry typedef {addr_t pc; word_t inst}.
//  Sub-module if_queue: circular buffer with multi-push (<= W), multi-pop (<= W), flush, and count,
//  parametrised by W and Q_DEPTH.
//  cpu_fetch_buf holds the PC register, hit-prefix and accept logic, redirect arbitration, REV,
//  and the perf counters.
// TESTING
//  1 Reset: rst_n low mid-stream with 5 entries queued -> dec_valid_out=0, dec_inst_out=OP_NOP;
//    after release ic_pc_out lane0=0, lane1=4.
//  2 W=2, all hit, dec_take=2: inst 32'h13000000 -> dec_inst 32'h00000013. pc steps 0,8,16.
//    dec_pc 0/4, then 8/12.
//  3 Hit pattern {lane0=1, lane1=0} -> 1 entry pushed, pc 0->4. Lane0 miss with lane1 hit
//    -> 0 pushed, pc holds.
//  4 dec_take=0, Q_DEPTH=8, all hit -> count 2,4,6,8. Then ic_en_out=0 and pc holds.
//    dec_take=1 while full -> exactly 1 pushed next cycle. Verify wrap-around order.
//  5 en_jmp0=1 jmp_addr0=32'h100, en_jmp1=1 jmp_addr1=32'h200, queue holds 6 entries
//    -> next cycle dec_valid_out=0, ic_pc_out lane0=32'h100.
//  6 rdy=0 for 3 cycles with hits and dec_take=2 -> queue and pc unchanged.
//    With FETCH_PERF_EN: redirect counter +1 per redirect, stall counter increments on full queue.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared fetch-path types: address/word aliases, the NOP encoding, byte reversal and the queue entry.
package cpu_defs;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    localparam word_t OP_NOP = 32'h0000_0013;

    typedef struct packed {
        addr_t pc;
        word_t inst;
    } fetch_entry_t;

    // Icache returns little-endian words; the decoder expects them byte-reversed.
    function automatic word_t rev(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/if_queue.sv
// Circular instruction queue with up to W pushes and W pops per cycle, flush and exact occupancy count.
module if_queue
    import cpu_defs::*;
#(
    parameter  int unsigned W       = 2,
    parameter  int unsigned Q_DEPTH = 8,
    localparam int unsigned NW      = $clog2(W + 1),
    localparam int unsigned CW      = $clog2(Q_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic [NW-1:0]          push_n,
    input  fetch_entry_t [W-1:0]   push_data,
    input  logic [NW-1:0]          pop_n,
    output fetch_entry_t [W-1:0]   rd_data,
    output logic [W-1:0]           rd_valid,
    output logic [CW-1:0]          count
);

    localparam int unsigned PW = $clog2(Q_DEPTH);

    fetch_entry_t      mem [Q_DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     cnt;

    // Separate occupancy counter keeps full/empty exact; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (en) begin
            if (flush) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                head <= head + PW'(pop_n);
                tail <= tail + PW'(push_n);
                cnt  <= cnt + CW'(push_n) - CW'(pop_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && !flush) begin
            for (int i = 0; i < int'(W); i++) begin
                if (NW'(i) < push_n) begin
                    mem[tail + PW'(i)] <= push_data[i];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < int'(W); j++) begin
            rd_valid[j] = cnt > CW'(j);
            rd_data[j]  = mem[head + PW'(j)];
        end
    end

    assign count = cnt;

endmodule

// File: rtl/cpu_fetch_buf.sv
// N-wide fetch stage: PC, hit-prefix accept, redirect arbitration and decoupling queue to the decoder.
// Optional FETCH_PERF_EN adds stall and redirect counters.
module cpu_fetch_buf
    import cpu_defs::*;
#(
    parameter  int unsigned FETCH_W  = 2,
    parameter  int unsigned Q_DEPTH  = 8,
    parameter  addr_t       RESET_PC = 32'h0,
    localparam int unsigned TAKE_W   = $clog2(FETCH_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    output addr_t [FETCH_W-1:0]   ic_pc_out,
    output logic  [FETCH_W-1:0]   ic_en_out,
    input  logic  [FETCH_W-1:0]   ic_hit,
    input  word_t [FETCH_W-1:0]   ic_inst,
    input  logic                  en_jmp0,
    input  addr_t                 jmp_addr0,
    input  logic                  en_jmp1,
    input  addr_t                 jmp_addr1,
    output logic  [FETCH_W-1:0]   dec_valid_out,
    output addr_t [FETCH_W-1:0]   dec_pc_out,
    output word_t [FETCH_W-1:0]   dec_inst_out,
`ifdef FETCH_PERF_EN
    output logic  [31:0]          perf_stall_cnt,
    output logic  [31:0]          perf_redir_cnt,
`endif
    input  logic  [TAKE_W-1:0]    dec_take
);

    localparam int unsigned CW = $clog2(Q_DEPTH + 1);

    addr_t                     pc;
    logic [CW-1:0]             q_count;
    logic [CW-1:0]             free;
    logic [TAKE_W-1:0]         hit_n;
    logic [TAKE_W-1:0]         acc_n;
    logic [TAKE_W-1:0]         valid_n;
    logic [TAKE_W-1:0]         take_n;
    logic                      run;
    logic                      redirect;
    addr_t                     target;
    fetch_entry_t [FETCH_W-1:0] push_data;
    fetch_entry_t [FETCH_W-1:0] rd_data;
    logic [FETCH_W-1:0]        rd_valid;

    assign free     = CW'(Q_DEPTH) - q_count;
    assign redirect = en_jmp0 | en_jmp1;
    assign target   = (en_jmp0 ? jmp_addr0 : jmp_addr1) & ~32'h3;

    // Contiguous hit prefix, limited by queue space; also clamps decoder take to what is visible.
    always_comb begin
        hit_n = '0;
        run   = 1'b1;
        for (int i = 0; i < int'(FETCH_W); i++) begin
            run = run & ic_hit[i];
            if (run) hit_n = hit_n + TAKE_W'(1);
        end
        acc_n   = (CW'(hit_n) > free) ? TAKE_W'(free) : hit_n;
        valid_n = (q_count > CW'(FETCH_W)) ? TAKE_W'(FETCH_W) : TAKE_W'(q_count);
        take_n  = (dec_take > valid_n) ? valid_n : dec_take;
    end

    always_comb begin
        for (int i = 0; i < int'(FETCH_W); i++) begin
            ic_pc_out[i]         = pc + 32'(4 * i);
            ic_en_out[i]         = free > CW'(i);
            push_data[i].pc      = pc + 32'(4 * i);
            push_data[i].inst    = rev(ic_inst[i]);
            dec_valid_out[i]     = rd_valid[i];
            dec_pc_out[i]        = rd_valid[i] ? rd_data[i].pc : '0;
            dec_inst_out[i]      = rd_valid[i] ? rd_data[i].inst : OP_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (rdy) begin
            if (redirect) pc <= target;
            else          pc <= pc + (32'(acc_n) << 2);
        end
    end

    if_queue #(
        .W       (FETCH_W),
        .Q_DEPTH (Q_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (rdy),
        .flush     (redirect),
        .push_n    (redirect ? '0 : acc_n),
        .push_data (push_data),
        .pop_n     (take_n),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst_n && rdy && !redirect) begin
            assert (dec_take <= valid_n)
                else $error("cpu_fetch_buf: dec_take %0d exceeds visible entries %0d", dec_take, valid_n);
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_redir_cnt <= '0;
        end else if (rdy) begin
            if (redirect)             perf_redir_cnt <= perf_redir_cnt + 32'd1;
            else if (acc_n == '0)     perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_fetch_buf.sv
// Directed bench for cpu_fetch_buf (FETCH_W=2, Q_DEPTH=8): prefix accept, full/wrap, redirect, stall, reset.
module tb_cpu_fetch_buf;
    import cpu_defs::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy;
    addr_t [1:0]   ic_pc_out;
    logic  [1:0]   ic_en_out;
    logic  [1:0]   ic_hit;
    word_t [1:0]   ic_inst;
    logic          en_jmp0;
    addr_t         jmp_addr0;
    logic          en_jmp1;
    addr_t         jmp_addr1;
    logic  [1:0]   dec_valid_out;
    addr_t [1:0]   dec_pc_out;
    word_t [1:0]   dec_inst_out;
    logic  [1:0]   dec_take;
`ifdef FETCH_PERF_EN
    logic  [31:0]  perf_stall_cnt;
    logic  [31:0]  perf_redir_cnt;
`endif

    int            n_assert = 0;
    int            n_fail   = 0;
    logic          use_lit  = 1'b0;
    word_t [1:0]   lit;

    cpu_fetch_buf #(.FETCH_W(2), .Q_DEPTH(8), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .ic_pc_out     (ic_pc_out),
        .ic_en_out     (ic_en_out),
        .ic_hit        (ic_hit),
        .ic_inst       (ic_inst),
        .en_jmp0       (en_jmp0),
        .jmp_addr0     (jmp_addr0),
        .en_jmp1       (en_jmp1),
        .jmp_addr1     (jmp_addr1),
        .dec_valid_out (dec_valid_out),
        .dec_pc_out    (dec_pc_out),
        .dec_inst_out  (dec_inst_out),
`ifdef FETCH_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
        .perf_redir_cnt(perf_redir_cnt),
`endif
        .dec_take      (dec_take)
    );

    always #5 clk = ~clk;

    // Icache data: raw little-endian word tagged with the low PC byte.
    function automatic word_t raw(input addr_t a);
        return {a[7:0], 8'h5A, 8'hC3, 8'h11};
    endfunction

    function automatic word_t exp_inst(input addr_t a);
        return {8'h11, 8'hC3, 8'h5A, a[7:0]};
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ic_inst[i] = use_lit ? lit[i] : raw(ic_pc_out[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; ic_hit = 2'b00; dec_take = 2'd0;
        en_jmp0 = 1'b0; jmp_addr0 = '0; en_jmp1 = 1'b0; jmp_addr1 = '0;
        lit = '0;
        #2;
        check("rst_valid", 32'(dec_valid_out), 32'h0);
        check("rst_inst0", dec_inst_out[0], OP_NOP);
        check("rst_pc0", dec_pc_out[0], 32'h0);
        check("rst_icpc0", ic_pc_out[0], 32'h0);
        check("rst_icpc1", ic_pc_out[1], 32'h4);
        check("rst_icen", 32'(ic_en_out), 32'h3);
        step();
        rst_n = 1'b1;

        // All hit, byte reversal, sequential PC stepping
        use_lit = 1'b1; lit[0] = 32'h1300_0000; lit[1] = 32'h3300_0000;
        ic_hit = 2'b11; dec_take = 2'd0;
        step();
        check("t2_valid", 32'(dec_valid_out), 32'h3);
        check("t2_dpc0", dec_pc_out[0], 32'h0);
        check("t2_dpc1", dec_pc_out[1], 32'h4);
        check("t2_inst0", dec_inst_out[0], 32'h0000_0013);
        check("t2_inst1", dec_inst_out[1], 32'h0000_0033);
        check("t2_icpc8", ic_pc_out[0], 32'h8);
        dec_take = 2'd2;
        step();
        check("t2_dpc0b", dec_pc_out[0], 32'h8);
        check("t2_dpc1b", dec_pc_out[1], 32'hC);
        check("t2_icpc16", ic_pc_out[0], 32'h10);
        ic_hit = 2'b00;
        step();
        check("t2_empty", 32'(dec_valid_out), 32'h0);
        check("t2_nop", dec_inst_out[0], OP_NOP);
        check("t2_hold", ic_pc_out[0], 32'h10);
        use_lit = 1'b0;

        // Partial hit prefix
        ic_hit = 2'b01; dec_take = 2'd0;
        step();
        check("t3_valid", 32'(dec_valid_out), 32'h1);
        check("t3_dpc0", dec_pc_out[0], 32'h10);
        check("t3_inst0", dec_inst_out[0], exp_inst(32'h10));
        check("t3_inst1nop", dec_inst_out[1], OP_NOP);
        check("t3_icpc", ic_pc_out[0], 32'h14);
        ic_hit = 2'b10;
        step();
        check("t3_miss0_valid", 32'(dec_valid_out), 32'h1);
        check("t3_miss0_pc", ic_pc_out[0], 32'h14);
        ic_hit = 2'b00; dec_take = 2'd1;
        step();
        check("t3_drain", 32'(dec_valid_out), 32'h0);

        // Fill to full, single-slot refill, wrap-around drain order
        ic_hit = 2'b11; dec_take = 2'd0;
        step(); check("t4_en_c2", 32'(ic_en_out), 32'h3);
        step(); check("t4_en_c4", 32'(ic_en_out), 32'h3);
        step(); check("t4_en_c6", 32'(ic_en_out), 32'h3);
        step(); check("t4_en_full", 32'(ic_en_out), 32'h0);
        check("t4_pc_full", ic_pc_out[0], 32'h34);
        step();
        check("t4_pc_hold", ic_pc_out[0], 32'h34);
        check("t4_head", dec_pc_out[0], 32'h14);
        dec_take = 2'd1;
        step();
        check("t4_en_one", 32'(ic_en_out), 32'h1);
        check("t4_head2", dec_pc_out[0], 32'h18);
        dec_take = 2'd0;
        step();
        check("t4_pc_one", ic_pc_out[0], 32'h38);
        check("t4_en_full2", 32'(ic_en_out), 32'h0);
        check("t4_o0", dec_pc_out[0], 32'h18);
        check("t4_o1", dec_pc_out[1], 32'h1C);
        ic_hit = 2'b00; dec_take = 2'd2;
        step();
        check("t4_o2", dec_pc_out[0], 32'h20);
        check("t4_o3", dec_pc_out[1], 32'h24);
        check("t4_o2inst", dec_inst_out[0], exp_inst(32'h20));
        step();
        check("t4_o4", dec_pc_out[0], 32'h28);
        check("t4_o5", dec_pc_out[1], 32'h2C);
        step();
        check("t4_o6", dec_pc_out[0], 32'h30);
        check("t4_o7", dec_pc_out[1], 32'h34);
        check("t4_o7inst", dec_inst_out[1], exp_inst(32'h34));
        step();
        check("t4_empty", 32'(dec_valid_out), 32'h0);
        check("t4_en_empty", 32'(ic_en_out), 32'h3);

        // Redirect with both ports active; port 0 wins and the queue flushes
        ic_hit = 2'b11; dec_take = 2'd0;
        step(); step(); step();
        check("t5_six_en", 32'(ic_en_out), 32'h3);
        check("t5_six_head", dec_pc_out[0], 32'h38);
        en_jmp0 = 1'b1; jmp_addr0 = 32'h100; en_jmp1 = 1'b1; jmp_addr1 = 32'h200;
        dec_take = 2'd2;
        step();
        check("t5_flush", 32'(dec_valid_out), 32'h0);
        check("t5_icpc0", ic_pc_out[0], 32'h100);
        check("t5_icpc1", ic_pc_out[1], 32'h104);
        en_jmp0 = 1'b0; en_jmp1 = 1'b0; dec_take = 2'd0;
        step();
        check("t5_tgt_valid", 32'(dec_valid_out), 32'h3);
        check("t5_tgt_pc0", dec_pc_out[0], 32'h100);
        check("t5_tgt_pc1", dec_pc_out[1], 32'h104);
        check("t5_tgt_inst1", dec_inst_out[1], exp_inst(32'h104));
        ic_hit = 2'b00; en_jmp1 = 1'b1; jmp_addr1 = 32'h203;
        step();
        check("t5_p1_flush", 32'(dec_valid_out), 32'h0);
        check("t5_p1_align", ic_pc_out[0], 32'h200);
        en_jmp1 = 1'b0;

        // rdy=0 freezes everything, including pending take and redirect
        ic_hit = 2'b11;
        step();
        rdy = 1'b0; dec_take = 2'd2; en_jmp0 = 1'b1; jmp_addr0 = 32'h300;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_stall_valid", 32'(dec_valid_out), 32'h3);
            check("t6_stall_head", dec_pc_out[0], 32'h200);
            check("t6_stall_pc", ic_pc_out[0], 32'h208);
        end
        rdy = 1'b1; en_jmp0 = 1'b0; dec_take = 2'd0; ic_hit = 2'b00;
        step();
        check("t6_after_pc1", dec_pc_out[1], 32'h204);
        check("t6_after_icpc", ic_pc_out[0], 32'h208);

        // 32-bit PC wrap
        en_jmp0 = 1'b1; jmp_addr0 = 32'hFFFF_FFF8;
        step();
        check("wrap_lane1", ic_pc_out[1], 32'hFFFF_FFFC);
        en_jmp0 = 1'b0; ic_hit = 2'b11;
        step();
        check("wrap_pc", ic_pc_out[0], 32'h0);
        check("wrap_dpc1", dec_pc_out[1], 32'hFFFF_FFFC);

        // Asynchronous reset with 5 entries queued
        step();
        ic_hit = 2'b01;
        step();
        check("t1_pre_valid", 32'(dec_valid_out), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("t1_valid", 32'(dec_valid_out), 32'h0);
        check("t1_inst0", dec_inst_out[0], OP_NOP);
        check("t1_inst1", dec_inst_out[1], OP_NOP);
        check("t1_dpc0", dec_pc_out[0], 32'h0);
        check("t1_icpc0", ic_pc_out[0], 32'h0);
        check("t1_icpc1", ic_pc_out[1], 32'h4);
        ic_hit = 2'b00;
        step();
        rst_n = 1'b1; ic_hit = 2'b11;
        step();
        check("t1_post_dpc0", dec_pc_out[0], 32'h0);
        check("t1_post_dpc1", dec_pc_out[1], 32'h4);
        check("t1_post_icpc", ic_pc_out[0], 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
